// File: rtl/apb_mem_completer.sv
// apb_mem_completer: APB completer with word-addressed memory, wait states, error counter and ID register
// Ports:
//   apb_clk, sys_reset         clock (rising edge) and asynchronous active-low reset
//   apb_selx, apb_en           PSEL / PENABLE
//   apb_write, apb_addr        direction and word address, sampled in the setup phase
//   apb_wdata                  write data, taken in the completion cycle
//   apb_rdata, apb_slverr      response, forced to 0 while apb_ready=0
//   apb_ready                  PREADY, decoded from registered state only
module apb_mem_completer #(
    parameter int          DEPTH    = 32,
    parameter int          DEF_WAIT = 0,
    parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic        apb_clk,
    input  logic        sys_reset,
    input  logic        apb_selx,
    input  logic        apb_en,
    input  logic        apb_write,
    input  logic [7:0]  apb_addr,
    input  logic [31:0] apb_wdata,
    output logic [31:0] apb_rdata,
    output logic        apb_ready,
    output logic        apb_slverr
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] MEM_END = 8'(DEPTH);

    state_t      state;
    logic [3:0]  wait_cnt, wait_cfg;
    logic [15:0] err_cnt;
    logic [7:0]  addr_q;
    logic        write_q, slverr_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH];
    logic        mem_hit, setup_err, done;
    logic [31:0] rd_val;

    always_comb begin
        mem_hit   = apb_addr < MEM_END;
        rd_val    = mem_hit ? mem[apb_addr[AW-1:0]] :
                    apb_addr == 8'hF0 ? {28'b0, wait_cfg} :
                    apb_addr == 8'hF4 ? {16'b0, err_cnt} :
                    apb_addr == 8'hFC ? ID_VALUE : '0;
        setup_err = !(mem_hit || apb_addr == 8'hF0 || apb_addr == 8'hF4 || apb_addr == 8'hFC) ||
                    (apb_write && apb_addr == 8'hFC);
    end

    assign apb_ready  = state == ACCESS && wait_cnt == 4'd0;
    assign done       = apb_ready && apb_selx && apb_en;
    assign apb_rdata  = apb_ready ? rdata_q : '0;
    assign apb_slverr = apb_ready && slverr_q;

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wait_cfg <= 4'(DEF_WAIT);
            err_cnt  <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == IDLE) begin
            // PENABLE already high in IDLE is a protocol violation and is ignored
            if (apb_selx && !apb_en) begin
                addr_q   <= apb_addr;
                write_q  <= apb_write;
                wait_cnt <= wait_cfg;
                slverr_q <= setup_err;
                rdata_q  <= apb_write ? '0 : rd_val;
                state    <= ACCESS;
            end
        end else if (!apb_selx) begin
            state <= IDLE;
        end else if (done) begin
            state <= IDLE;
            if (slverr_q)
                err_cnt <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
            else if (write_q) begin
                if (addr_q < MEM_END) mem[addr_q[AW-1:0]] <= apb_wdata;
                else if (addr_q == 8'hF0) wait_cfg <= apb_wdata[3:0];
                else if (addr_q == 8'hF4) err_cnt <= '0;
            end
        end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_apb_mem_completer.sv
// tb_apb_mem_completer: directed self-checking bench for apb_mem_completer
module tb_apb_mem_completer;
    logic        apb_clk = 1'b0;
    logic        sys_reset = 1'b0;
    logic        apb_selx = 1'b0;
    logic        apb_en = 1'b0;
    logic        apb_write = 1'b0;
    logic [7:0]  apb_addr = '0;
    logic [31:0] apb_wdata = '0;
    logic [31:0] apb_rdata;
    logic        apb_ready;
    logic        apb_slverr;
    int          n_checks = 0;
    int          n_errors = 0;

    apb_mem_completer dut (
        .apb_clk(apb_clk), .sys_reset(sys_reset), .apb_selx(apb_selx), .apb_en(apb_en),
        .apb_write(apb_write), .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_rdata(apb_rdata), .apb_ready(apb_ready), .apb_slverr(apb_slverr)
    );

    always #5 apb_clk = ~apb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transfer; counts access cycles with ready=0 before completion
    task automatic xfer(input string tag, input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input int exp_waits, input logic [31:0] exp_rd, input logic exp_err);
        int waits;
        @(posedge apb_clk); #1;
        apb_selx = 1'b1; apb_en = 1'b0; apb_write = wr; apb_addr = a; apb_wdata = d;
        @(posedge apb_clk); #1;
        apb_en = 1'b1;
        waits = 0;
        while (!apb_ready && waits < 50) begin
            @(posedge apb_clk); #1;
            waits++;
        end
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_err"}, {31'b0, apb_slverr}, {31'b0, exp_err});
        if (!wr) check({tag, "_rdata"}, apb_rdata, exp_rd);
        @(posedge apb_clk); #1;
        apb_selx = 1'b0; apb_en = 1'b0;
        check({tag, "_idle"}, {31'b0, apb_ready}, 32'd0);
    endtask

    initial begin
        #2;
        check("rst_ready", {31'b0, apb_ready}, 32'd0);
        check("rst_rdata", apb_rdata, 32'd0);
        check("rst_err", {31'b0, apb_slverr}, 32'd0);
        #21 sys_reset = 1'b1;

        xfer("rd_wcfg_def", 1'b0, 8'hF0, 0, 0, 32'd0, 1'b0);
        xfer("rd_id", 1'b0, 8'hFC, 0, 0, 32'hA9B00001, 1'b0);
        xfer("wr_a4", 1'b1, 8'h04, 32'h0000000A, 0, 0, 1'b0);
        xfer("rd_a4", 1'b0, 8'h04, 0, 0, 32'h0000000A, 1'b0);

        xfer("wr_wcfg3", 1'b1, 8'hF0, 32'd3, 0, 0, 1'b0);
        xfer("rd_wcfg3", 1'b0, 8'hF0, 0, 3, 32'd3, 1'b0);
        xfer("wr_a5", 1'b1, 8'h05, 32'h0000000C, 3, 0, 1'b0);
        xfer("rd_a5", 1'b0, 8'h05, 0, 3, 32'h0000000C, 1'b0);

        xfer("rd_unmap", 1'b0, 8'h64, 0, 3, 32'd0, 1'b1);
        xfer("wr_id", 1'b1, 8'hFC, 32'h12345678, 3, 0, 1'b1);
        xfer("rd_id2", 1'b0, 8'hFC, 0, 3, 32'hA9B00001, 1'b0);
        xfer("rd_errcnt2", 1'b0, 8'hF4, 0, 3, 32'd2, 1'b0);
        xfer("wr_errcnt", 1'b1, 8'hF4, 32'hFFFFFFFF, 3, 0, 1'b0);
        xfer("rd_errcnt0", 1'b0, 8'hF4, 0, 3, 32'd0, 1'b0);

        // setup with PENABLE already high is ignored
        @(posedge apb_clk); #1;
        apb_selx = 1'b1; apb_en = 1'b1; apb_write = 1'b0; apb_addr = 8'h04;
        repeat (3) begin
            @(posedge apb_clk); #1;
            check("viol_ready", {31'b0, apb_ready}, 32'd0);
        end
        apb_selx = 1'b0; apb_en = 1'b0;

        xfer("wr_wcfg5", 1'b1, 8'hF0, 32'd5, 3, 0, 1'b0);
        xfer("wr_a2", 1'b1, 8'h02, 32'h00000011, 5, 0, 1'b0);

        // abort after two access cycles
        @(posedge apb_clk); #1;
        apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 8'h02; apb_wdata = 32'h55;
        @(posedge apb_clk); #1;
        apb_en = 1'b1;
        check("abort_acc0", {31'b0, apb_ready}, 32'd0);
        @(posedge apb_clk); #1;
        check("abort_acc1", {31'b0, apb_ready}, 32'd0);
        apb_selx = 1'b0; apb_en = 1'b0;
        repeat (6) begin
            @(posedge apb_clk); #1;
            check("abort_ready", {31'b0, apb_ready}, 32'd0);
        end
        xfer("rd_a2_kept", 1'b0, 8'h02, 0, 5, 32'h00000011, 1'b0);
        xfer("rd_errcnt_ab", 1'b0, 8'hF4, 0, 5, 32'd0, 1'b0);

        // reset during a wait state of a pending write
        @(posedge apb_clk); #1;
        apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 8'h02; apb_wdata = 32'h77;
        @(posedge apb_clk); #1;
        apb_en = 1'b1;
        @(posedge apb_clk); #1;
        sys_reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, apb_ready}, 32'd0);
        check("mid_rst_rdata", apb_rdata, 32'd0);
        apb_selx = 1'b0; apb_en = 1'b0;
        #10 sys_reset = 1'b1;
        xfer("rd_wcfg_rst", 1'b0, 8'hF0, 0, 0, 32'd0, 1'b0);
        xfer("rd_a2_rst", 1'b0, 8'h02, 0, 0, 32'd0, 1'b0);
        xfer("rd_a4_rst", 1'b0, 8'h04, 0, 0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
